// File: rtl/tmds_ctrl_if.sv
// TMDS controller bus: encoder-side inputs and the stage, mux and serializer controls.
interface tmds_ctrl_if;
  logic       en;
  logic       de;
  logic       pre_start;
  logic       D1_load;
  logic       D2_load;
  logic       S1_load;
  logic       L2_load;
  logic       S2_load;
  logic       s_rst;
  logic [1:0] out_sel;
  logic       pre_active;
  logic       SR0_load;
  logic       SR1_load;
  logic       shiftmuxsel;
  logic       err;

  // Timing source / stimulus side
  modport master (
    output en, de, pre_start,
    input  D1_load, D2_load, S1_load, L2_load, S2_load, s_rst, out_sel, pre_active,
    input  SR0_load, SR1_load, shiftmuxsel, err
  );

  // Controller side
  modport slave (
    input  en, de, pre_start,
    output D1_load, D2_load, S1_load, L2_load, S2_load, s_rst, out_sel, pre_active,
    output SR0_load, SR1_load, shiftmuxsel, err
  );
endinterface

// File: rtl/tmds_ctrl.sv
// TMDS transmit sequencer: de delay line, CTRL/PRE/GUARD/VIDEO output selection,
// ping-pong serializer control. Define TMDS_CTRL_ERR_EN to build the sticky err flag;
// without it err is tied low and the FSM behaves identically.
module tmds_ctrl #(
  parameter int unsigned PRE_LEN   = 8,
  parameter int unsigned GUARD_LEN = 2
) (
  input logic        clk,
  input logic        n_rst,  // active-high asynchronous reset
  tmds_ctrl_if.slave bus
);

  localparam logic [1:0] StCtrl  = 2'd0;
  localparam logic [1:0] StPre   = 2'd1;
  localparam logic [1:0] StGuard = 2'd2;
  localparam logic [1:0] StVideo = 2'd3;

  localparam logic [3:0] PreLast   = 4'(PRE_LEN - 1);
  localparam logic [3:0] GuardLast = 4'(GUARD_LEN - 1);

  logic [1:0] r_state, w_state_d, w_state_eff;
  logic [3:0] r_cnt, w_cnt_d;
  logic [5:1] r_tap;  // r_tap[n] = de from n enabled cycles ago
  logic       r_phase;
  logic       r_smux;
  logic       w_err_set;

  assign bus.D1_load     = bus.en;
  assign bus.D2_load     = bus.en;
  assign bus.S1_load     = bus.en;
  assign bus.L2_load     = bus.en;
  assign bus.S2_load     = bus.en;
  assign bus.s_rst       = bus.en & ~r_tap[3];
  assign bus.SR0_load    = bus.en & ~r_phase;
  assign bus.SR1_load    = bus.en & r_phase;
  assign bus.shiftmuxsel = r_smux;

  // VIDEO whose tap5 has dropped is already a blanking word, so it acts as CTRL this cycle
  assign w_state_eff = (r_state == StVideo && !r_tap[5]) ? StCtrl : r_state;

  // Output mux select and preamble flag from the effective state
  always_comb begin
    bus.out_sel    = 2'b01;
    bus.pre_active = 1'b0;
    case (w_state_eff)
      StPre:   bus.pre_active = 1'b1;
      StGuard: bus.out_sel    = 2'b10;
      StVideo: bus.out_sel    = 2'b00;
      default: bus.out_sel    = 2'b01;
    endcase
  end

  // Next state; tap4 is the value tap5 takes on the next enabled cycle
  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_err_set = 1'b0;
    if (bus.en) begin
      w_state_d = w_state_eff;
      case (w_state_eff)
        StCtrl: begin
          if (bus.pre_start) begin
            w_state_d = StPre;
            w_cnt_d   = 4'd0;
          end else if (r_tap[4] && !r_tap[5]) begin
            w_state_d = StVideo;
            w_err_set = 1'b1;
          end
        end
        StPre: begin
          w_err_set = bus.pre_start;
          if (r_cnt == PreLast) begin
            w_state_d = StGuard;
            w_cnt_d   = 4'd0;
          end else begin
            w_cnt_d = r_cnt + 4'd1;
          end
        end
        StGuard: begin
          w_err_set = bus.pre_start;
          if (r_cnt == GuardLast) begin
            w_cnt_d = 4'd0;
            if (r_tap[4]) begin
              w_state_d = StVideo;
            end else begin
              w_state_d = StCtrl;
              w_err_set = 1'b1;
            end
          end else begin
            w_cnt_d = r_cnt + 4'd1;
          end
        end
        default: w_err_set = bus.pre_start;
      endcase
    end
  end

  // FSM state and counter
  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      r_state <= StCtrl;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
    end
  end

  // de delay line and serializer ping-pong phase, advancing only on enabled cycles
  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      r_tap   <= 5'd0;
      r_phase <= 1'b0;
      r_smux  <= 1'b0;
    end else if (bus.en) begin
      r_tap   <= {r_tap[4:1], bus.de};
      r_phase <= ~r_phase;
      r_smux  <= r_phase;
    end
  end

`ifdef TMDS_CTRL_ERR_EN
  logic r_err;

  // Sticky sequencing error, cleared only by reset
  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      r_err <= 1'b0;
    end else if (w_err_set) begin
      r_err <= 1'b1;
    end
  end

  assign bus.err = r_err;
`else
  logic w_unused_err_set;
  assign w_unused_err_set = w_err_set;
  assign bus.err          = 1'b0;
`endif

endmodule

// File: tb/tb_tmds_ctrl.sv
// Self-checking bench for tmds_ctrl: a per-cycle vector table for a full video period
// plus directed sequences for free-running blanking, missing preamble, missing de,
// en stalls inside the preamble and reset during video.
module tb_tmds_ctrl;
  logic clk = 1'b0;
  logic n_rst;

  tmds_ctrl_if bus ();

  tmds_ctrl #(
    .PRE_LEN  (8),
    .GUARD_LEN(2)
  ) u_dut (
    .clk  (clk),
    .n_rst(n_rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

`ifdef TMDS_CTRL_ERR_EN
  localparam logic ErrEn = 1'b1;
`else
  localparam logic ErrEn = 1'b0;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  typedef struct {
    logic       en;
    logic       de;
    logic       ps;
    logic [1:0] out_sel;
    logic       pre_active;
    logic       s_rst;
    logic       sr0;
    logic       sr1;
    logic       smux;
  } vec_t;

  vec_t tv[34];

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic drive(input logic en, input logic de, input logic ps);
    bus.en        = en;
    bus.de        = de;
    bus.pre_start = ps;
  endtask

  // Move to 1 time unit after the next rising edge (start of the next cycle)
  task automatic adv();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Hold reset with en=1, check reset-time outputs, release just after an edge: cycle 0
  task automatic do_reset();
    drive(1'b1, 1'b0, 1'b0);
    n_rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_out_sel", bus.out_sel, 4'h1);
    chk("rst_pre_active", bus.pre_active, 4'h0);
    chk("rst_sr0_load", bus.SR0_load, 4'h1);
    chk("rst_sr1_load", bus.SR1_load, 4'h0);
    chk("rst_d1_load", bus.D1_load, 4'h1);
    chk("rst_s_rst", bus.s_rst, 4'h1);
    chk("rst_smux", bus.shiftmuxsel, 4'h0);
    chk("rst_err", bus.err, 4'h0);
    @(posedge clk);
    #1;
    n_rst = 1'b0;
    cyc   = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cycle=%0d got=timeout expected=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Full video period: pre_start at 10, de over 16..25
    for (int c = 0; c < 34; c++) begin
      tv[c].en         = 1'b1;
      tv[c].de         = (c >= 16 && c <= 25);
      tv[c].ps         = (c == 10);
      tv[c].out_sel    = (c >= 11 && c <= 18) ? 2'b01 :
                         (c == 19 || c == 20) ? 2'b10 :
                         (c >= 21 && c <= 30) ? 2'b00 : 2'b01;
      tv[c].pre_active = (c >= 11 && c <= 18);
      tv[c].s_rst      = !(c >= 19 && c <= 28);
      tv[c].sr0        = (c % 2 == 0);
      tv[c].sr1        = (c % 2 == 1);
      tv[c].smux       = (c != 0) && (c % 2 == 0);
    end

    // Blanking only
    do_reset();
    for (int c = 0; c < 20; c++) begin
      drive(1'b1, 1'b0, 1'b0);
      @(negedge clk);
      chk("idle_out_sel", bus.out_sel, 4'h1);
      chk("idle_s_rst", bus.s_rst, 4'h1);
      chk("idle_sr0", bus.SR0_load, 4'(c % 2 == 0));
      chk("idle_sr1", bus.SR1_load, 4'(c % 2 == 1));
      chk("idle_err", bus.err, 4'h0);
      adv();
    end

    // Table-driven normal sequence
    do_reset();
    for (int i = 0; i < 34; i++) begin
      drive(tv[i].en, tv[i].de, tv[i].ps);
      @(negedge clk);
      chk("tv_out_sel", bus.out_sel, 4'(tv[i].out_sel));
      chk("tv_pre_active", bus.pre_active, 4'(tv[i].pre_active));
      chk("tv_s_rst", bus.s_rst, 4'(tv[i].s_rst));
      chk("tv_sr0", bus.SR0_load, 4'(tv[i].sr0));
      chk("tv_sr1", bus.SR1_load, 4'(tv[i].sr1));
      chk("tv_smux", bus.shiftmuxsel, 4'(tv[i].smux));
      chk("tv_err", bus.err, 4'h0);
      adv();
    end

    // de without preamble: straight to video, no guard
    do_reset();
    for (int c = 0; c < 33; c++) begin
      drive(1'b1, (c >= 16 && c <= 25), 1'b0);
      @(negedge clk);
      if (c == 20) chk("nopre_out_sel20", bus.out_sel, 4'h1);
      if (c == 20) chk("nopre_err20", bus.err, 4'h0);
      if (c == 21) chk("nopre_out_sel21", bus.out_sel, 4'h0);
      if (c == 21) chk("nopre_err21", bus.err, 4'(ErrEn));
      if (c == 31) chk("nopre_out_sel31", bus.out_sel, 4'h1);
      if (c == 32) chk("nopre_err_sticky", bus.err, 4'(ErrEn));
      adv();
    end

    // Preamble and guard with no de following
    do_reset();
    for (int c = 0; c < 23; c++) begin
      drive(1'b1, 1'b0, (c == 10));
      @(negedge clk);
      if (c == 19 || c == 20) chk("node_guard", bus.out_sel, 4'h2);
      if (c == 20) chk("node_err20", bus.err, 4'h0);
      if (c == 21) chk("node_out_sel21", bus.out_sel, 4'h1);
      if (c == 21) chk("node_err21", bus.err, 4'(ErrEn));
      if (c == 22) chk("node_pre_active22", bus.pre_active, 4'h0);
      adv();
    end

    // en low for cycles 13..15 inside the preamble
    do_reset();
    for (int c = 0; c < 25; c++) begin
      drive(!(c >= 13 && c <= 15), 1'b0, (c == 10));
      @(negedge clk);
      if (c >= 13 && c <= 15) begin
        chk("stall_d1", bus.D1_load, 4'h0);
        chk("stall_s2", bus.S2_load, 4'h0);
        chk("stall_sr0", bus.SR0_load, 4'h0);
        chk("stall_sr1", bus.SR1_load, 4'h0);
        chk("stall_s_rst", bus.s_rst, 4'h0);
        chk("stall_out_sel", bus.out_sel, 4'h1);
        chk("stall_pre_active", bus.pre_active, 4'h1);
        chk("stall_smux", bus.shiftmuxsel, 4'h0);
      end
      if (c == 16) chk("resume_sr1", bus.SR1_load, 4'h1);
      if (c == 16) chk("resume_smux16", bus.shiftmuxsel, 4'h0);
      if (c == 17) chk("resume_smux17", bus.shiftmuxsel, 4'h1);
      if (c == 21) chk("stall_pre_last", bus.pre_active, 4'h1);
      if (c == 22) chk("stall_pre_done", bus.pre_active, 4'h0);
      if (c == 22 || c == 23) chk("stall_guard", bus.out_sel, 4'h2);
      if (c == 24) chk("stall_ctrl", bus.out_sel, 4'h1);
      adv();
    end

    // Stray pre_start during video, then asynchronous reset during video
    do_reset();
    for (int c = 0; c < 24; c++) begin
      drive(1'b1, (c >= 16), (c == 10 || c == 22));
      @(negedge clk);
      if (c == 23) chk("stray_out_sel", bus.out_sel, 4'h0);
      if (c == 23) chk("stray_err", bus.err, 4'(ErrEn));
      if (c == 23) chk("stray_pre_active", bus.pre_active, 4'h0);
      adv();
    end
    drive(1'b1, 1'b1, 1'b0);
    #2;
    chk("prerst_out_sel", bus.out_sel, 4'h0);
    chk("prerst_smux", bus.shiftmuxsel, 4'h1);
    n_rst = 1'b1;
    #1;
    chk("midrst_out_sel", bus.out_sel, 4'h1);
    chk("midrst_err", bus.err, 4'h0);
    chk("midrst_smux", bus.shiftmuxsel, 4'h0);
    chk("midrst_pre_active", bus.pre_active, 4'h0);
    @(posedge clk);
    #1;
    n_rst = 1'b0;
    cyc   = 0;
    for (int c = 0; c < 6; c++) begin
      drive(1'b1, 1'b1, 1'b0);
      @(negedge clk);
      if (c == 4) chk("postrst_out_sel4", bus.out_sel, 4'h1);
      if (c == 4) chk("postrst_err4", bus.err, 4'h0);
      if (c == 5) chk("postrst_out_sel5", bus.out_sel, 4'h0);
      if (c == 5) chk("postrst_err5", bus.err, 4'(ErrEn));
      adv();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
